// File: rtl/pokemon_pkg.sv
// Shared types and constants for the overworld player movement logic.
// Directions, keycodes, step FSM states and tile geometry.
package pokemon_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        CHECK = 2'd2,
        WALK  = 2'd3
    } step_state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam int TILE_PX = 16;

    // Bit 6 of the result flags a step off the 0..63 grid (no wrap).
    function automatic logic [6:0] step_axis(
        input logic [5:0] c,
        input logic       inc,
        input logic       dec
    );
        logic [6:0] r;
        r = {1'b0, c};
        if (inc)
            r = r + 7'd1;
        else if (dec)
            r = r - 7'd1;
        return r;
    endfunction

endpackage

// File: rtl/keycode_to_dir.sv
// Maps a USB HID keycode onto a movement direction.
// Keys other than W/A/S/D report valid = 0.
module keycode_to_dir
    import pokemon_pkg::*;
(
    input  logic [7:0] keycode,
    output logic       valid,
    output dir_t       dir
);

    // Pure lookup of the four movement keys
    always_comb begin
        valid = 1'b1;
        dir   = UP;
        case (keycode)
            KEY_W:   dir = UP;
            KEY_D:   dir = RIGHT;
            KEY_S:   dir = DOWN;
            KEY_A:   dir = LEFT;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/player_step_ctrl.sv
// Tile-step movement controller for the player sprite.
// Turns keys into turn/check/walk steps paced by frame_tick.
module player_step_ctrl
    import pokemon_pkg::*;
#(
    parameter logic [5:0] START_X      = 6'd10,
    parameter logic [5:0] START_Y      = 6'd10,
    parameter int         PX_PER_FRAME = 1,
    parameter int         TURN_FRAMES  = 4,
    parameter int         ANIM_DIV     = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       blocked,
    output logic [5:0] tgt_x,
    output logic [5:0] tgt_y,
    output logic       Character_Moving,
    output logic [1:0] Direction,
    output logic [1:0] anim_frame,
    output logic [5:0] pos_x,
    output logic [5:0] pos_y,
    output logic [3:0] offset,
    output logic       step_done
);

    localparam logic [7:0] TURN_LAST = 8'(TURN_FRAMES - 1);
    localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

    step_state_t state;
    step_state_t state_next;

    logic       key_valid;
    dir_t       key_dir;
    logic       chk_phase;
    logic       tgt_oob;
    logic [7:0] turn_cnt;
    logic [7:0] anim_cnt;
    logic       load_dir;
    logic       start_check;
    logic       step_end;
    logic [4:0] offset_sum;
    logic [5:0] base_x;
    logic [5:0] base_y;
    logic [6:0] nx;
    logic [6:0] ny;

    keycode_to_dir u_dec (
        .keycode (keycode),
        .valid   (key_valid),
        .dir     (key_dir)
    );

    assign offset_sum = {1'b0, offset} + 5'(PX_PER_FRAME);
    assign step_end   = (state == WALK) && frame_tick &&
                        (offset_sum >= 5'(TILE_PX));

    // A chained step queries from the tile being entered this edge
    assign base_x = step_end ? tgt_x : pos_x;
    assign base_y = step_end ? tgt_y : pos_y;
    assign nx = step_axis(base_x, Direction == RIGHT, Direction == LEFT);
    assign ny = step_axis(base_y, Direction == DOWN, Direction == UP);

    assign Character_Moving = (state == WALK);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and per-edge control strobes
    always_comb begin
        state_next  = state;
        load_dir    = 1'b0;
        start_check = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_tick && key_valid) begin
                    if (key_dir != dir_t'(Direction)) begin
                        state_next = TURN;
                        load_dir   = 1'b1;
                    end else begin
                        state_next  = CHECK;
                        start_check = 1'b1;
                    end
                end
            end
            TURN: begin
                if (frame_tick && turn_cnt == TURN_LAST)
                    state_next = IDLE;
            end
            CHECK: begin
                if (chk_phase)
                    state_next = (tgt_oob || blocked) ? IDLE : WALK;
            end
            WALK: begin
                if (step_end) begin
                    if (key_valid && key_dir == dir_t'(Direction)) begin
                        state_next  = CHECK;
                        start_check = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    // Position, target, counters and animation datapath
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Direction  <= 2'd0;
            pos_x      <= START_X;
            pos_y      <= START_Y;
            tgt_x      <= START_X;
            tgt_y      <= START_Y;
            tgt_oob    <= 1'b0;
            offset     <= 4'd0;
            anim_frame <= 2'd0;
            anim_cnt   <= 8'd0;
            turn_cnt   <= 8'd0;
            chk_phase  <= 1'b0;
            step_done  <= 1'b0;
        end else begin
            step_done <= step_end;
            chk_phase <= (state == CHECK) && !chk_phase;

            if (load_dir)
                Direction <= key_dir;

            if (state != TURN)
                turn_cnt <= 8'd0;
            else if (frame_tick)
                turn_cnt <= (turn_cnt == TURN_LAST) ? 8'd0 : turn_cnt + 8'd1;

            if (state == WALK && frame_tick) begin
                if (step_end) begin
                    offset <= 4'd0;
                    pos_x  <= tgt_x;
                    pos_y  <= tgt_y;
                end else begin
                    offset <= offset_sum[3:0];
                end
            end

            if (state_next == IDLE) begin
                anim_cnt   <= 8'd0;
                anim_frame <= 2'd0;
            end else if (state == WALK && frame_tick) begin
                if (anim_cnt == ANIM_LAST) begin
                    anim_cnt   <= 8'd0;
                    anim_frame <= anim_frame + 2'd1;
                end else begin
                    anim_cnt <= anim_cnt + 8'd1;
                end
            end

            if (start_check) begin
                tgt_oob <= nx[6] | ny[6];
                tgt_x   <= nx[6] ? base_x : nx[5:0];
                tgt_y   <= ny[6] ? base_y : ny[5:0];
            end
        end
    end

endmodule

// File: tb/tb_player_step_ctrl.sv
// Directed testbench for player_step_ctrl.
// Linear step sequence with immediate assertions per check.
module tb_player_step_ctrl;
    import pokemon_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic [7:0] keycode;
    logic       blocked;
    logic [5:0] tgt_x;
    logic [5:0] tgt_y;
    logic       Character_Moving;
    logic [1:0] Direction;
    logic [1:0] anim_frame;
    logic [5:0] pos_x;
    logic [5:0] pos_y;
    logic [3:0] offset;
    logic       step_done;

    int n_chk  = 0;
    int n_fail = 0;

    player_step_ctrl dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_tick       (frame_tick),
        .keycode          (keycode),
        .blocked          (blocked),
        .tgt_x            (tgt_x),
        .tgt_y            (tgt_y),
        .Character_Moving (Character_Moving),
        .Direction        (Direction),
        .anim_frame       (anim_frame),
        .pos_x            (pos_x),
        .pos_y            (pos_y),
        .offset           (offset),
        .step_done        (step_done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse frame_tick; returns at the negedge right after the sampling edge
    task automatic tick();
        repeat (5) @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    function automatic logic [7:0] st();
        return {6'd0, dut.state};
    endfunction

    initial begin
        Reset      = 1'b1;
        frame_tick = 1'b0;
        keycode    = 8'h00;
        blocked    = 1'b0;
        repeat (2) @(negedge Clk);

        chk("rst_state", st(), 8'(IDLE));
        chk("rst_dir", 8'(Direction), 8'd0);
        chk("rst_pos_x", 8'(pos_x), 8'd10);
        chk("rst_pos_y", 8'(pos_y), 8'd10);
        chk("rst_tgt_x", 8'(tgt_x), 8'd10);
        chk("rst_tgt_y", 8'(tgt_y), 8'd10);
        chk("rst_offset", 8'(offset), 8'd0);
        chk("rst_anim", 8'(anim_frame), 8'd0);
        chk("rst_moving", 8'(Character_Moving), 8'd0);
        chk("rst_done", 8'(step_done), 8'd0);
        Reset = 1'b0;

        // Hold up: first step, then a chained second step
        keycode = KEY_W;
        tick();
        chk("up_check", st(), 8'(CHECK));
        chk("up_tgt_y", 8'(tgt_y), 8'd9);
        repeat (2) @(negedge Clk);
        chk("up_walk", st(), 8'(WALK));
        chk("up_moving", 8'(Character_Moving), 8'd1);
        for (int k = 2; k <= 17; k++) begin
            tick();
            if (k < 17) begin
                chk("up_offset", 8'(offset), 8'(k - 1));
                chk("up_anim", 8'(anim_frame), 8'(((k - 1) / 4) % 4));
                chk("up_nodone", 8'(step_done), 8'd0);
            end else begin
                chk("up_done", 8'(step_done), 8'd1);
                chk("up_pos_y", 8'(pos_y), 8'd9);
                chk("up_off0", 8'(offset), 8'd0);
            end
        end
        @(negedge Clk);
        chk("up_done_1cyc", 8'(step_done), 8'd0);
        chk("up_chain", st(), 8'(CHECK));
        repeat (3) tick();
        chk("up2_offset", 8'(offset), 8'd3);
        keycode = 8'h00;
        repeat (13) tick();
        chk("up2_done", 8'(step_done), 8'd1);
        chk("up2_pos_y", 8'(pos_y), 8'd8);
        chk("up2_idle", st(), 8'(IDLE));
        chk("up2_anim0", 8'(anim_frame), 8'd0);

        // Tap right: turn only
        keycode = KEY_D;
        tick();
        keycode = 8'h00;
        chk("tap_dir", 8'(Direction), 8'd1);
        chk("tap_turn", st(), 8'(TURN));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tap_state", st(), (i < 3) ? 8'(TURN) : 8'(IDLE));
            chk("tap_moving", 8'(Character_Moving), 8'd0);
        end
        chk("tap_pos_x", 8'(pos_x), 8'd10);
        chk("tap_pos_y", 8'(pos_y), 8'd8);

        // Hold down against a blocked tile
        keycode = KEY_S;
        blocked = 1'b1;
        tick();
        chk("blk_dir", 8'(Direction), 8'd2);
        repeat (4) tick();
        chk("blk_idle0", st(), 8'(IDLE));
        tick();
        chk("blk_check", st(), 8'(CHECK));
        repeat (2) @(negedge Clk);
        chk("blk_idle", st(), 8'(IDLE));
        chk("blk_moving", 8'(Character_Moving), 8'd0);
        chk("blk_pos_y", 8'(pos_y), 8'd8);
        tick();
        chk("blk_retry", st(), 8'(CHECK));
        repeat (2) @(negedge Clk);
        chk("blk_idle2", st(), 8'(IDLE));

        // Walk left to the map edge, then push against it
        blocked = 1'b0;
        keycode = KEY_A;
        repeat (166) tick();
        chk("edge_pos_x", 8'(pos_x), 8'd0);
        chk("edge_pos_y", 8'(pos_y), 8'd8);
        chk("edge_done", 8'(step_done), 8'd1);
        chk("edge_dir", 8'(Direction), 8'd3);
        repeat (2) @(negedge Clk);
        chk("edge_idle", st(), 8'(IDLE));
        tick();
        chk("edge_check", st(), 8'(CHECK));
        repeat (2) @(negedge Clk);
        chk("edge_idle2", st(), 8'(IDLE));
        chk("edge_moving", 8'(Character_Moving), 8'd0);
        chk("edge_pos_x2", 8'(pos_x), 8'd0);

        // Hold right: chained steps, then reset mid-walk
        keycode = KEY_D;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (i == 22) begin
                chk("chain_pos1", 8'(pos_x), 8'd1);
                chk("chain_done1", 8'(step_done), 8'd1);
            end
            if (i == 23)
                chk("chain_nogap", st(), 8'(WALK));
            if (i == 30)
                chk("chain_anim", 8'(anim_frame), 8'd2);
            if (i == 38) begin
                chk("chain_pos2", 8'(pos_x), 8'd2);
                chk("chain_done2", 8'(step_done), 8'd1);
            end
            if (i == 42)
                chk("chain_anim2", 8'(anim_frame), 8'd1);
        end
        chk("mid_offset", 8'(offset), 8'd7);
        Reset = 1'b1;
        @(negedge Clk);
        chk("mr_state", st(), 8'(IDLE));
        chk("mr_pos_x", 8'(pos_x), 8'd10);
        chk("mr_pos_y", 8'(pos_y), 8'd10);
        chk("mr_offset", 8'(offset), 8'd0);
        chk("mr_dir", 8'(Direction), 8'd0);
        chk("mr_done", 8'(step_done), 8'd0);
        chk("mr_moving", 8'(Character_Moving), 8'd0);
        Reset = 1'b0;
        keycode = 8'h00;
        @(negedge Clk);
        chk("mr_done_after", 8'(step_done), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
